bnn_instr_seq: RTL and testbench
================================

Name: bnn_instr_seq

Overview:
- Layer sequencer that drives a BNN core's 20-bit instruction bus and 32-bit data bus for one layer.
- Fetches configuration, bias, image and weight words from an upstream valid/ready stream.
- Issues the per-output sequence: accumulator clear, operand load, partial-sum accumulate over the active BPU groups, binarize (with optional 2x2 OR-pooling), and periodic result store strobes.
- Sits between the layer DMA/buffer and the core.

Parameters:
- N_GROUPS_MAX, 16, number of BPU groups addressable by bpug_sel (4-bit field).
- LOAD_W, 8, width of the operand-load word count.
- OUT_W, 10, width of the output (binarized result) count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle pulse that begins a layer. Ignored while busy=1.
- cfg_enable  in  16  BPU group enable mask, sent to the core in the CFG word.
- cfg_height  in  3  kernel height, sent in the CFG word.
- cfg_groups  in  5  number of groups accumulated per pass, 1..16. A value of 0 is treated as 16.
- cfg_load_len  in  LOAD_W  operand words per pass. A value of 0 skips LOAD.
- cfg_outputs  in  OUT_W  number of binarized results for the layer.
- cfg_pool  in  1  1 = each result is the OR of 4 passes.
- src_data  in  32  upstream word.
- src_valid  in  1  upstream word valid.
- src_ready  out  1  sequencer accepts a word. A transfer occurs when src_valid & src_ready.
- instruction  out  20  registered instruction to the core.
- data_out  out  32  registered data to the core.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of the layer.
- res_strobe  out  1  high in store cycles; a downstream capture is valid here.
- res_half  out  1  in store cycles, 0 = low half, 1 = high half.

Behaviour:
- Configuration capture: all cfg_* inputs are sampled on the accepted start and held for the whole layer.
- Instruction fields:
  - [0] acc_clear/bias preload.
  - [4:1] bpug_sel.
  - [8:5] group control; 0 unless stated.
  - [9] psum_add.
  - [10] cal_bin_wr.
  - [11] bias_wr.
  - [12] pool_en.
  - [13] pool_sel.
  - [14] store.
  - [15] img_reg_up.
  - [16] img_reg_sel.
  - [19:17] wgt_sel.
  - Any bit not listed for a state is 0.
- Outputs are registered: the value issued in state S appears one cycle after entering S.
- Reset values: instruction=0, data_out=0, busy=0, done=0, res_strobe=0, res_half=0, src_ready=0. The FSM returns to IDLE.
  - Reset mid-layer aborts immediately. No done pulse is produced.
- States:
  - IDLE: NOP (instruction 0). On start, go to CFG.
  - CFG, 1 cycle: instr = bit15|bit8 (0x08100). data_out = {8'h00, 5'b0, height, enable[15:0]}.
  - BIAS, 2 words: src_ready=1.
    - Per transfer: instr = bit11 (0x00800), data_out = src_data.
    - Without a transfer, issue NOP.
    - If cfg_outputs=0, go to DONE afterwards; otherwise go to CLR.
  - CLR, 1 cycle: instr = 0x00001.
  - LOAD, cfg_load_len words, word index w counting from 0: src_ready=1.
    - Per transfer: instr bit15=1, bit16=w[0], [19:17]=w[3:1]; data_out = src_data.
    - A stall issues NOP and does not advance w.
  - ACC, cfg_groups cycles, g = 0..G-1: instr = bit9 | (g<<1).
  - BIN, 1 cycle: instr = bit10.
    - If pool: also bit12, bit13=pass[0], bit6=pass[1].
  - Pass handling after BIN:
    - If pool and pass<3: pass++, go to CLR.
    - Otherwise: pass=0, res_cnt++. If res_cnt%8==0 or res_cnt==cfg_outputs, go to STORE; otherwise go to CLR.
  - STORE, 2 cycles:
    - instr = bit14 (0x04000) with res_strobe=1, res_half=0.
    - then instr = 0x04040 with res_strobe=1, res_half=1.
    - Afterwards: if res_cnt==cfg_outputs go to DONE, else go to CLR.
  - DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Counters:
  - w: LOAD_W bits.
  - g: 5 bits.
  - pass: 2 bits.
  - res_cnt: OUT_W bits. No wrap within a layer because cfg_outputs bounds it.
- A start arriving in the DONE cycle is ignored.

Test Plan:
- Basic layer (pool=0, outputs=1, groups=2, load_len=0, src_valid=1). Start at cycle 0 -> cycle 1 0x08100; cycles 2-3 0x00800; cycle 4 0x00001; cycle 5 0x00200; cycle 6 0x00202; cycle 7 0x00400; cycles 8-9 0x04000/0x04040 with res_strobe; done at cycle 10.
- CFG data check: enable=0xA5C3, height=5 -> data_out=0x0005A5C3 in the CFG cycle.
- LOAD with stalls (load_len=3, src_valid toggling 1,0,1,1):
  - instr bit15 appears only on transfers, with bit16/wgt_sel following w=0,1,2.
  - NOP is issued on the stall.
  - Exactly 3 words are accepted.
- Pooling (pool=1, outputs=1):
  - 4 BIN cycles issued: 0x01400, 0x03400, 0x01440, 0x03440.
  - One STORE pair follows.
- Store cadence (outputs=10): STORE pairs after the 8th and 10th BIN, then done.
- Reset and edge cases:
  - Assert rst during ACC -> next cycle instruction=0, busy=0, no done pulse.
  - A following start runs a full layer.
  - cfg_outputs=0 -> CFG, BIAS, then done.

Source files
------------

// File: rtl/bnn_instr_seq.sv
// Layer sequencer for a BNN core: streams config/bias/operand words from an
// upstream valid/ready source and issues the per-output instruction sequence.
module bnn_instr_seq #(
  parameter int N_GROUPS_MAX = 16,
  parameter int LOAD_W       = 8,
  parameter int OUT_W        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       cfg_enable,
  input  logic [2:0]        cfg_height,
  input  logic [4:0]        cfg_groups,
  input  logic [LOAD_W-1:0] cfg_load_len,
  input  logic [OUT_W-1:0]  cfg_outputs,
  input  logic              cfg_pool,
  input  logic [31:0]       src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [19:0]       instruction,
  output logic [31:0]       data_out,
  output logic              busy,
  output logic              done,
  output logic              res_strobe,
  output logic              res_half
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_BIAS, S_CLR, S_LOAD, S_ACC, S_BIN, S_STORE, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [15:0]       enable_reg;
  logic [2:0]        height_reg;
  logic [4:0]        groups_reg;
  logic [LOAD_W-1:0] load_len_reg;
  logic [OUT_W-1:0]  outputs_reg;
  logic              pool_reg;

  logic              bias_cnt_reg;
  logic [LOAD_W-1:0] w_reg;
  logic [4:0]        g_reg;
  logic [1:0]        pass_reg;
  logic [OUT_W-1:0]  res_cnt_reg;
  logic              half_reg;

  logic              xfer;
  logic              w_last;
  logic              g_last;
  logic              bin_last;
  logic [OUT_W-1:0]  res_cnt_inc;
  logic [3:0]        w_lo;

  logic [19:0]       instr_next;
  logic [31:0]       data_next;
  logic              busy_next, done_next, strobe_next, half_next;

  assign src_ready   = (state_reg == S_BIAS) || (state_reg == S_LOAD);
  assign xfer        = src_valid && src_ready;
  assign w_last      = (w_reg == load_len_reg - LOAD_W'(1));
  assign g_last      = (g_reg == groups_reg - 5'd1);
  assign bin_last    = !pool_reg || (pass_reg == 2'd3);
  assign res_cnt_inc = res_cnt_reg + OUT_W'(1);
  assign w_lo        = 4'(w_reg);

  // State register plus the layer configuration and loop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      enable_reg   <= '0;
      height_reg   <= '0;
      groups_reg   <= '0;
      load_len_reg <= '0;
      outputs_reg  <= '0;
      pool_reg     <= 1'b0;
      bias_cnt_reg <= 1'b0;
      w_reg        <= '0;
      g_reg        <= '0;
      pass_reg     <= '0;
      res_cnt_reg  <= '0;
      half_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start) begin
        enable_reg   <= cfg_enable;
        height_reg   <= cfg_height;
        groups_reg   <= (cfg_groups == 5'd0) ? 5'(N_GROUPS_MAX) : cfg_groups;
        load_len_reg <= cfg_load_len;
        outputs_reg  <= cfg_outputs;
        pool_reg     <= cfg_pool;
        bias_cnt_reg <= 1'b0;
        w_reg        <= '0;
        g_reg        <= '0;
        pass_reg     <= '0;
        res_cnt_reg  <= '0;
        half_reg     <= 1'b0;
      end
      if (state_reg == S_BIAS && xfer) bias_cnt_reg <= ~bias_cnt_reg;
      if (state_reg == S_LOAD && xfer) w_reg <= w_last ? '0 : w_reg + LOAD_W'(1);
      if (state_reg == S_ACC) g_reg <= g_last ? 5'd0 : g_reg + 5'd1;
      if (state_reg == S_BIN) begin
        pass_reg <= bin_last ? 2'd0 : pass_reg + 2'd1;
        if (bin_last) res_cnt_reg <= res_cnt_inc;
      end
      if (state_reg == S_STORE) half_reg <= ~half_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_CFG;
      S_CFG:   state_next = S_BIAS;
      S_BIAS:  if (xfer && bias_cnt_reg)
                 state_next = (outputs_reg == '0) ? S_DONE : S_CLR;
      S_CLR:   state_next = (load_len_reg != '0) ? S_LOAD : S_ACC;
      S_LOAD:  if (xfer && w_last) state_next = S_ACC;
      S_ACC:   if (g_last) state_next = S_BIN;
      S_BIN: begin
        // A result is complete only after the last pooling pass
        if (!bin_last)
          state_next = S_CLR;
        else if (res_cnt_inc[2:0] == 3'd0 || res_cnt_inc == outputs_reg)
          state_next = S_STORE;
        else
          state_next = S_CLR;
      end
      S_STORE: if (half_reg)
                 state_next = (res_cnt_reg == outputs_reg) ? S_DONE : S_CLR;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    instr_next  = '0;
    data_next   = '0;
    strobe_next = 1'b0;
    half_next   = 1'b0;
    busy_next   = (state_reg != S_IDLE) && (state_reg != S_DONE);
    done_next   = (state_reg == S_DONE);
    case (state_reg)
      S_CFG: begin
        instr_next = 20'h08100;
        data_next  = {8'h00, 5'b0, height_reg, enable_reg};
      end
      S_BIAS: if (xfer) begin
        instr_next = 20'h00800;
        data_next  = src_data;
      end
      S_CLR: instr_next = 20'h00001;
      S_LOAD: if (xfer) begin
        instr_next[15]    = 1'b1;
        instr_next[16]    = w_lo[0];
        instr_next[19:17] = w_lo[3:1];
        data_next         = src_data;
      end
      S_ACC: begin
        instr_next[9]   = 1'b1;
        instr_next[4:1] = g_reg[3:0];
      end
      S_BIN: begin
        instr_next[10] = 1'b1;
        if (pool_reg) begin
          instr_next[12] = 1'b1;
          instr_next[13] = pass_reg[0];
          instr_next[6]  = pass_reg[1];
        end
      end
      S_STORE: begin
        instr_next[14] = 1'b1;
        instr_next[6]  = half_reg;
        strobe_next    = 1'b1;
        half_next      = half_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= '0;
      data_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_strobe  <= 1'b0;
      res_half    <= 1'b0;
    end else begin
      instruction <= instr_next;
      data_out    <= data_next;
      busy        <= busy_next;
      done        <= done_next;
      res_strobe  <= strobe_next;
      res_half    <= half_next;
    end
  end

endmodule

// File: tb/tb_bnn_instr_seq.sv
// Directed bench for bnn_instr_seq; cycle k means the outputs seen after the
// k-th rising edge counted from the edge that samples start (edge 0).
module tb_bnn_instr_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_enable;
  logic [2:0]  cfg_height;
  logic [4:0]  cfg_groups;
  logic [7:0]  cfg_load_len;
  logic [9:0]  cfg_outputs;
  logic        cfg_pool;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [19:0] instruction;
  logic [31:0] data_out;
  logic        busy, done, res_strobe, res_half;

  int total = 0;
  int bad   = 0;

  logic [19:0] tr_i  [0:63];
  logic [31:0] tr_d  [0:63];
  logic        tr_s  [0:63];
  logic        tr_h  [0:63];
  logic        tr_b  [0:63];
  logic        tr_dn [0:63];
  logic        tr_x  [0:63];

  bnn_instr_seq #(.N_GROUPS_MAX(16), .LOAD_W(8), .OUT_W(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_enable(cfg_enable), .cfg_height(cfg_height), .cfg_groups(cfg_groups),
    .cfg_load_len(cfg_load_len), .cfg_outputs(cfg_outputs), .cfg_pool(cfg_pool),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .instruction(instruction), .data_out(data_out), .busy(busy), .done(done),
    .res_strobe(res_strobe), .res_half(res_half)
  );

  always #5 clk = ~clk;

  // Pulse start and record n cycles; vpat[k] is src_valid for edge k
  task automatic run_layer(input int n, input logic [63:0] vpat);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      src_valid = vpat[k];
      src_data  = 32'hD000_0000 | 32'(k);
      #1;
      tr_x[k] = src_valid & src_ready;
      @(negedge clk);
      start    = 1'b0;
      tr_i[k]  = instruction;
      tr_d[k]  = data_out;
      tr_s[k]  = res_strobe;
      tr_h[k]  = res_half;
      tr_b[k]  = busy;
      tr_dn[k] = done;
    end
    src_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [4:0] groups, input logic [7:0] len,
                         input logic [9:0] outs, input logic pool);
    cfg_enable   = 16'hA5C3;
    cfg_height   = 3'd5;
    cfg_groups   = groups;
    cfg_load_len = len;
    cfg_outputs  = outs;
    cfg_pool     = pool;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (instruction !== 20'h0 || data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
        res_strobe !== 1'b0 || res_half !== 1'b0 || src_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: instr=%h data=%h busy=%b done=%b strobe=%b half=%b ready=%b, want all zero",
               instruction, data_out, busy, done, res_strobe, res_half, src_ready);
    end
  endtask

  task automatic test_basic_layer;
    logic [19:0] exp_i [0:11];
    exp_i = '{20'h0, 20'h08100, 20'h00800, 20'h00800, 20'h00001, 20'h00200,
              20'h00202, 20'h00400, 20'h04000, 20'h04040, 20'h0, 20'h0};
    set_cfg(5'd2, 8'd0, 10'd1, 1'b0);
    run_layer(14, '1);
    for (int k = 0; k < 12; k++) begin
      total++;
      if (tr_i[k] !== exp_i[k]) begin
        bad++;
        $display("FAIL basic_instr[%0d]: got %h want %h", k, tr_i[k], exp_i[k]);
      end
    end
    total++;
    if (tr_d[1] !== 32'h0005A5C3) begin
      bad++; $display("FAIL cfg_data: got %h want 0005a5c3", tr_d[1]);
    end
    total++;
    if (tr_d[2] !== 32'hD0000002 || tr_d[3] !== 32'hD0000003) begin
      bad++; $display("FAIL bias_data: got %h %h want d0000002 d0000003", tr_d[2], tr_d[3]);
    end
    total++;
    if ({tr_s[7], tr_s[8], tr_s[9], tr_s[10]} !== 4'b0110 || tr_h[8] !== 1'b0 || tr_h[9] !== 1'b1) begin
      bad++;
      $display("FAIL basic_store: strobe7..10=%b%b%b%b half8=%b half9=%b want 0110 0 1",
               tr_s[7], tr_s[8], tr_s[9], tr_s[10], tr_h[8], tr_h[9]);
    end
    total++;
    if ({tr_b[0], tr_b[1], tr_b[9], tr_b[10]} !== 4'b0110) begin
      bad++; $display("FAIL basic_busy: busy0,1,9,10=%b%b%b%b want 0110", tr_b[0], tr_b[1], tr_b[9], tr_b[10]);
    end
    total++;
    if ({tr_dn[9], tr_dn[10], tr_dn[11]} !== 3'b010) begin
      bad++; $display("FAIL basic_done: done9..11=%b%b%b want 010", tr_dn[9], tr_dn[10], tr_dn[11]);
    end
  endtask

  task automatic test_load_stall;
    logic [63:0] vpat;
    int nx;
    vpat = '1;
    vpat[6] = 1'b0;
    set_cfg(5'd1, 8'd3, 10'd1, 1'b0);
    run_layer(16, vpat);
    total++;
    if (tr_i[5] !== 20'h08000 || tr_d[5] !== 32'hD0000005) begin
      bad++; $display("FAIL load_w0: instr %h data %h want 08000 d0000005", tr_i[5], tr_d[5]);
    end
    total++;
    if (tr_i[6] !== 20'h0) begin
      bad++; $display("FAIL load_stall_nop: instr %h want 00000", tr_i[6]);
    end
    total++;
    if (tr_i[7] !== 20'h18000 || tr_i[8] !== 20'h28000 || tr_d[8] !== 32'hD0000008) begin
      bad++; $display("FAIL load_w1_w2: instr %h %h data %h want 18000 28000 d0000008", tr_i[7], tr_i[8], tr_d[8]);
    end
    total++;
    if (tr_i[9] !== 20'h00200 || tr_i[10] !== 20'h00400 || tr_dn[13] !== 1'b1) begin
      bad++; $display("FAIL load_tail: acc %h bin %h done13 %b want 00200 00400 1", tr_i[9], tr_i[10], tr_dn[13]);
    end
    nx = 0;
    for (int k = 0; k < 16; k++) nx += int'(tr_x[k]);
    total++;
    if (nx != 5) begin
      bad++; $display("FAIL load_word_count: accepted %0d want 5 (2 bias + 3 load)", nx);
    end
  endtask

  task automatic test_pooling;
    logic [19:0] exp_bin [0:3];
    int cyc;
    exp_bin = '{20'h01400, 20'h03400, 20'h01440, 20'h03440};
    set_cfg(5'd1, 8'd0, 10'd1, 1'b1);
    run_layer(20, '1);
    for (int p = 0; p < 4; p++) begin
      cyc = 6 + 3 * p;
      total++;
      if (tr_i[cyc] !== exp_bin[p] || tr_i[cyc - 1] !== 20'h00200) begin
        bad++; $display("FAIL pool_pass%0d: bin %h acc %h want %h 00200", p, tr_i[cyc], tr_i[cyc - 1], exp_bin[p]);
      end
    end
    total++;
    if (tr_i[16] !== 20'h04000 || tr_i[17] !== 20'h04040 || tr_s[16] !== 1'b1 ||
        tr_s[15] !== 1'b0 || tr_dn[18] !== 1'b1) begin
      bad++;
      $display("FAIL pool_store: %h %h strobe15=%b strobe16=%b done18=%b want 04000 04040 0 1 1",
               tr_i[16], tr_i[17], tr_s[15], tr_s[16], tr_dn[18]);
    end
  endtask

  task automatic test_store_cadence;
    int ns;
    set_cfg(5'd1, 8'd0, 10'd10, 1'b0);
    run_layer(42, '1);
    ns = 0;
    for (int k = 0; k < 42; k++) ns += int'(tr_s[k]);
    total++;
    if (ns != 4) begin
      bad++; $display("FAIL cadence_strobe_count: %0d want 4", ns);
    end
    total++;
    if (tr_i[27] !== 20'h00400 || tr_i[28] !== 20'h04000 || tr_i[29] !== 20'h04040) begin
      bad++; $display("FAIL cadence_store8: %h %h %h want 00400 04000 04040", tr_i[27], tr_i[28], tr_i[29]);
    end
    total++;
    if (tr_i[36] !== 20'h04000 || tr_i[37] !== 20'h04040 || tr_dn[38] !== 1'b1 || tr_dn[37] !== 1'b0) begin
      bad++; $display("FAIL cadence_store10: %h %h done37=%b done38=%b want 04000 04040 0 1",
                      tr_i[36], tr_i[37], tr_dn[37], tr_dn[38]);
    end
  endtask

  task automatic test_reset_abort;
    set_cfg(5'd0, 8'd0, 10'd1, 1'b0);
    run_layer(6, '1);
    total++;
    if (tr_i[5] !== 20'h00200) begin
      bad++; $display("FAIL abort_in_acc: instr %h want 00200", tr_i[5]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (instruction !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_state: instr %h busy %b done %b want 00000 0 0", instruction, busy, done);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || instruction !== 20'h0) begin
        bad++; $display("FAIL abort_quiet[%0d]: done %b instr %h want 0 00000", k, done, instruction);
      end
    end
    set_cfg(5'd2, 8'd0, 10'd1, 1'b0);
    run_layer(12, '1);
    total++;
    if (tr_i[1] !== 20'h08100 || tr_i[6] !== 20'h00202 || tr_i[9] !== 20'h04040 || tr_dn[10] !== 1'b1) begin
      bad++; $display("FAIL restart_layer: %h %h %h done10=%b want 08100 00202 04040 1",
                      tr_i[1], tr_i[6], tr_i[9], tr_dn[10]);
    end
  endtask

  task automatic test_zero_outputs;
    int ns;
    set_cfg(5'd2, 8'd0, 10'd0, 1'b0);
    run_layer(8, '1);
    ns = 0;
    for (int k = 0; k < 8; k++) ns += int'(tr_s[k]);
    total++;
    if (tr_i[1] !== 20'h08100 || tr_i[3] !== 20'h00800 || tr_dn[4] !== 1'b1 ||
        tr_i[4] !== 20'h0 || tr_b[4] !== 1'b0 || tr_dn[5] !== 1'b0 || ns != 0) begin
      bad++; $display("FAIL zero_outputs: cfg %h bias %h instr4 %h done4 %b busy4 %b done5 %b strobes %0d",
                      tr_i[1], tr_i[3], tr_i[4], tr_dn[4], tr_b[4], tr_dn[5], ns);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
    set_cfg(5'd1, 8'd0, 10'd1, 1'b0);
    test_reset();
    test_basic_layer();
    test_load_stall();
    test_pooling();
    test_store_cadence();
    test_reset_abort();
    test_zero_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
